core_ctrl: RTL and testbench
============================

# core_ctrl

Instruction sequencer that sits directly upstream of the single-core datapath and drives its 20-bit `inst` bus for one complete attention tile. The pass loads Q and K vectors into qmem/kmem, loads the kernel and runs the MAC array, then drains the output FIFO into psum memory. It finishes with an SFP accumulate pass and a divide/write-back pass. A `start`/`done` handshake hands the whole sequence to the host or testbench.

## Interface
- `len`, default 8: Q/K vectors per tile and psum rows processed; legal range 1..16.
- `col`, default 8: kernel vectors loaded into the MAC array.
- `drain`, default 10: fixed wait in cycles between the end of execution and the first FIFO read; must be ≥1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request a tile pass; sampled only in IDLE.
- `inst` output 20: core instruction word.
- `ext_rd_add` output 5: index into the external vector source; `mem_in` must be valid in the same cycle.
- `busy` output 1: high in every non-IDLE, non-DONE state.
- `done` output 1: single-cycle completion pulse.

## Operation
Fixed `inst` encoding:
- [19] sfp_wr2pmem, [18] sfp_div, [17] sfp_acc, [16] ofifo_rd.
- [15:12] qkmem_add, [11:8] pmem_add, [7] mac execute, [6] kernel load / kmem select.
- [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
- Any field not listed for a state is 0.

Structure:
- Outputs are a Moore decode of the registered state and 5-bit counter `i`.
- No combinational path from `start` to any output.
- `i` clears on every state change.

States, in order:
- IDLE: `inst`=0. `start`=1 → LOAD_Q.
- LOAD_Q, `len` cycles: qmem_wr=1, qkmem_add=i, `ext_rd_add`=i.
- LOAD_K, `len` cycles: kmem_wr=1, qkmem_add=i, `ext_rd_add`=len+i.
- KLOAD, `col`+1 cycles:
  - [6]=1 in every cycle.
  - First `col` cycles: kmem_rd=1, qkmem_add=i.
  - Final cycle has kmem_rd=0 and covers SRAM read latency.
- EXEC, `len`+1 cycles:
  - [7]=1 in every cycle, [6]=0.
  - First `len` cycles: qmem_rd=1, qkmem_add=i.
  - Final cycle is the SRAM latency cycle.
- DRAIN, `drain` cycles: `inst`=0.
- READ, `len` cycles: ofifo_rd=1, pmem_wr=1, pmem_add=i. The FIFO is first-word-fall-through, so data is written the same cycle.
- ACC, 2 cycles per row r=0..len-1:
  - Phase 0: pmem_rd=1, pmem_add=r.
  - Phase 1: sfp_acc=1.
- DIV, 3 cycles per row r:
  - Phase 0: pmem_rd=1, pmem_add=r.
  - Phase 1: sfp_div=1.
  - Phase 2: pmem_wr=1, sfp_wr2pmem=1, pmem_add=r.
  - psum SRAM is single-port, so read and write never overlap.
- DONE, 1 cycle: `done`=1, `busy`=0, `inst`=0 → IDLE.

Boundary conditions:
- `start` outside IDLE is ignored, with no queuing.
- `start` held high across DONE begins a new pass on the cycle after IDLE is re-entered.
- `reset` at any time forces IDLE with `i`=0 at once. No partial instruction survives.
- `ext_rd_add` is 0 outside LOAD_Q/LOAD_K.
- The counter wraps only by state change and never exceeds max(len,col)·3.

## Timing
- Reset values: `inst`=0, `ext_rd_add`=0, `busy`=0, `done`=0.
- `start` sampled high at edge 0 → LOAD_Q active in cycle 1.
- Busy cycles per pass: 2·len + (col+1) + (len+1) + drain + len + 2·len + 3·len.
  - With defaults this is 92 cycles, cycles 1..92.
  - `done` is high in cycle 93.
  - IDLE in cycle 94, earliest restart sample.
- Per-row spacing: ACC 2 cycles, DIV 3 cycles. pmem_wr in DIV falls exactly 2 cycles after the matching pmem_rd.

## Test plan
- Reset, then no `start` for 20 cycles → `inst`=0, `busy`=0, `done`=0 throughout.
- Defaults, `start` pulse at cycle 0:
  - Cycles 1-8: qmem_wr with qkmem_add 0..7, `ext_rd_add` 0..7.
  - Cycles 9-16: kmem_wr with `ext_rd_add` 8..15.
  - `done` exactly at cycle 93.
- Defaults: every READ cycle has `inst`[16]=`inst`[0]=1 with pmem_add 0..7. DIV row 5 shows pmem_rd add 5, then sfp_div, then pmem_wr+wr2pmem add 5, with no cycle where pmem_rd=pmem_wr=1.
- `len`=1, `col`=8, `drain`=1 → `done` at cycle 1+1+1+9+2+1+1+2+3 = 21; KLOAD still issues 8 kernel reads.
- `start` re-pulsed during EXEC, and `reset` asserted mid-ACC:
  - The re-pulse has no effect.
  - On reset, `inst`/`busy` drop to 0 asynchronously.
  - A new `start` after reset release restarts at LOAD_Q with `ext_rd_add`=0.
- `start` held continuously → back-to-back passes, `done` at cycles 93 and 187.

Source files
------------

// File: rtl/core_ctrl_if.sv
// Host-facing bundle of the tile sequencer: start/done handshake, busy flag,
// core instruction word and external vector read address.
interface core_ctrl_if;
    logic        start;
    logic [19:0] inst;
    logic [4:0]  ext_rd_add;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        output inst,
        output ext_rd_add,
        output busy,
        output done
    );

    modport slave (
        output start,
        input  inst,
        input  ext_rd_add,
        input  busy,
        input  done
    );
endinterface

// File: rtl/core_ctrl.sv
// Attention-tile instruction sequencer: walks Q/K load, kernel load, MAC execute,
// FIFO drain, SFP accumulate and divide/write-back, driving the core inst bus.
module core_ctrl #(
    parameter int len   = 8,
    parameter int col   = 8,
    parameter int drain = 10
) (
    input  logic          clk,
    input  logic          reset,
    core_ctrl_if.master   bus
);

    localparam int SPAN_A = (len > col + 1) ? len : col + 1;
    localparam int SPAN_B = (SPAN_A > drain) ? SPAN_A : drain;
    localparam int CNT_W  = ($clog2(SPAN_B + 1) > 5) ? $clog2(SPAN_B + 1) : 5;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LEN_LAST   = cnt_t'(len - 1);
    localparam cnt_t KLOAD_LAST = cnt_t'(col);
    localparam cnt_t EXEC_LAST  = cnt_t'(len);
    localparam cnt_t DRAIN_LAST = cnt_t'(drain - 1);
    localparam cnt_t CNT_ONE    = cnt_t'(1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_Q,
        LOAD_K,
        KLOAD,
        EXEC,
        DRAIN,
        READ,
        ACC,
        DIV,
        DONE
    } state_t;

    state_t      state_q, state_d;
    cnt_t        i_q, i_d;
    logic [1:0]  ph_q, ph_d;

    logic [19:0] inst;
    logic [4:0]  ext_rd_add;
    logic        busy;
    logic        done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            ph_q    <= ph_d;
        end
    end

    // Every state transition clears both the index and the row phase.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        ph_d    = ph_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD_Q;
                    i_d     = '0;
                    ph_d    = '0;
                end
            end
            LOAD_Q: begin
                if (i_q == LEN_LAST) begin
                    state_d = LOAD_K;
                    i_d     = '0;
                end else begin
                    i_d = i_q + CNT_ONE;
                end
            end
            LOAD_K: begin
                if (i_q == LEN_LAST) begin
                    state_d = KLOAD;
                    i_d     = '0;
                end else begin
                    i_d = i_q + CNT_ONE;
                end
            end
            KLOAD: begin
                if (i_q == KLOAD_LAST) begin
                    state_d = EXEC;
                    i_d     = '0;
                end else begin
                    i_d = i_q + CNT_ONE;
                end
            end
            EXEC: begin
                if (i_q == EXEC_LAST) begin
                    state_d = DRAIN;
                    i_d     = '0;
                end else begin
                    i_d = i_q + CNT_ONE;
                end
            end
            DRAIN: begin
                if (i_q == DRAIN_LAST) begin
                    state_d = READ;
                    i_d     = '0;
                end else begin
                    i_d = i_q + CNT_ONE;
                end
            end
            READ: begin
                if (i_q == LEN_LAST) begin
                    state_d = ACC;
                    i_d     = '0;
                    ph_d    = '0;
                end else begin
                    i_d = i_q + CNT_ONE;
                end
            end
            ACC: begin
                if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else begin
                    ph_d = 2'd0;
                    if (i_q == LEN_LAST) begin
                        state_d = DIV;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + CNT_ONE;
                    end
                end
            end
            DIV: begin
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d = 2'd0;
                    if (i_q == LEN_LAST) begin
                        state_d = DONE;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + CNT_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                i_d     = '0;
                ph_d    = '0;
            end
            default: begin
                state_d = IDLE;
                i_d     = '0;
                ph_d    = '0;
            end
        endcase
    end

    // Moore decode: outputs depend only on registered state, index and phase.
    always_comb begin
        inst       = '0;
        ext_rd_add = '0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD_Q: begin
                inst[4]     = 1'b1;
                inst[15:12] = i_q[3:0];
                ext_rd_add  = i_q[4:0];
            end
            LOAD_K: begin
                inst[2]     = 1'b1;
                inst[15:12] = i_q[3:0];
                ext_rd_add  = 5'(len) + i_q[4:0];
            end
            KLOAD: begin
                inst[6] = 1'b1;
                if (i_q != KLOAD_LAST) begin
                    inst[3]     = 1'b1;
                    inst[15:12] = i_q[3:0];
                end
            end
            EXEC: begin
                inst[7] = 1'b1;
                if (i_q != EXEC_LAST) begin
                    inst[5]     = 1'b1;
                    inst[15:12] = i_q[3:0];
                end
            end
            DRAIN: begin
            end
            READ: begin
                inst[16]   = 1'b1;
                inst[0]    = 1'b1;
                inst[11:8] = i_q[3:0];
            end
            ACC: begin
                if (ph_q == 2'd0) begin
                    inst[1]    = 1'b1;
                    inst[11:8] = i_q[3:0];
                end else begin
                    inst[17] = 1'b1;
                end
            end
            DIV: begin
                // Read, divide, write back: the single-port psum SRAM never sees rd and wr together.
                if (ph_q == 2'd0) begin
                    inst[1]    = 1'b1;
                    inst[11:8] = i_q[3:0];
                end else if (ph_q == 2'd1) begin
                    inst[18] = 1'b1;
                end else begin
                    inst[19]   = 1'b1;
                    inst[0]    = 1'b1;
                    inst[11:8] = i_q[3:0];
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign bus.inst       = inst;
    assign bus.ext_rd_add = ext_rd_add;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: a default-size instance and a len=1/drain=1
// instance, each with an expected per-cycle instruction stream queued at start.
module tb_core_ctrl;

    typedef struct packed {
        int          cyc;
        logic [19:0] inst;
        logic [4:0]  ext;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    exp_t q0[$];
    exp_t q1[$];
    int   done_log0[$];
    int   done_log1[$];

    core_ctrl_if bus0();
    core_ctrl_if bus1();

    core_ctrl #(.len(8), .col(8), .drain(10)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    core_ctrl #(.len(1), .col(8), .drain(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int id, input int c, input logic [19:0] inst,
                        input logic [4:0] ext, input logic busy, input logic done);
        exp_t e;
        e.cyc = c; e.inst = inst; e.ext = ext; e.busy = busy; e.done = done;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Expected stream of one pass, written straight from the state list; first busy cycle is c.
    task automatic gen(input int id, input int L, input int C, input int D, input int c_first);
        int c;
        logic [19:0] w;
        c = c_first;
        for (int i = 0; i < L; i++) begin
            w = 20'h0; w[4] = 1'b1; w[15:12] = 4'(i);
            push(id, c++, w, 5'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < L; i++) begin
            w = 20'h0; w[2] = 1'b1; w[15:12] = 4'(i);
            push(id, c++, w, 5'(L + i), 1'b1, 1'b0);
        end
        for (int i = 0; i <= C; i++) begin
            w = 20'h0; w[6] = 1'b1;
            if (i < C) begin w[3] = 1'b1; w[15:12] = 4'(i); end
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
        end
        for (int i = 0; i <= L; i++) begin
            w = 20'h0; w[7] = 1'b1;
            if (i < L) begin w[5] = 1'b1; w[15:12] = 4'(i); end
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
        end
        for (int i = 0; i < D; i++) push(id, c++, 20'h0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < L; i++) begin
            w = 20'h0; w[16] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(i);
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
        end
        for (int r = 0; r < L; r++) begin
            w = 20'h0; w[1] = 1'b1; w[11:8] = 4'(r);
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
            w = 20'h0; w[17] = 1'b1;
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
        end
        for (int r = 0; r < L; r++) begin
            w = 20'h0; w[1] = 1'b1; w[11:8] = 4'(r);
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
            w = 20'h0; w[18] = 1'b1;
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
            w = 20'h0; w[19] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(r);
            push(id, c++, w, 5'd0, 1'b1, 1'b0);
        end
        push(id, c, 20'h0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic mon(input int id, input logic [19:0] inst, input logic [4:0] ext,
                       input logic busy, input logic done);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : q1.size();
        checks++;
        if (inst[1] && inst[0]) begin
            errors++;
            $display("FAIL dut%0d psum_rd_wr_overlap cyc=%0d inst=%h", id, cyc, inst);
        end
        if (busy || done) begin
            if (done) begin
                if (id == 0) done_log0.push_back(cyc);
                else         done_log1.push_back(cyc);
            end
            checks++;
            if (sz == 0) begin
                errors++;
                $display("FAIL dut%0d unexpected_output cyc=%0d inst=%h ext=%0d busy=%b done=%b",
                         id, cyc, inst, ext, busy, done);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q1.pop_front();
                if (e.cyc != cyc || e.inst !== inst || e.ext !== ext ||
                    e.busy !== busy || e.done !== done) begin
                    errors++;
                    $display("FAIL dut%0d stream got cyc=%0d inst=%h ext=%0d busy=%b done=%b, expected cyc=%0d inst=%h ext=%0d busy=%b done=%b",
                             id, cyc, inst, ext, busy, done, e.cyc, e.inst, e.ext, e.busy, e.done);
                end
            end
        end else begin
            if (inst !== 20'h0 || ext !== 5'd0) begin
                errors++;
                $display("FAIL dut%0d idle_outputs cyc=%0d got inst=%h ext=%0d, expected 0/0", id, cyc, inst, ext);
            end
            if (sz != 0) begin
                if (id == 0) e = q0[0];
                else         e = q1[0];
                if (e.cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d missing_output cyc=%0d got idle, expected inst=%h busy=%b done=%b",
                             id, cyc, e.inst, e.busy, e.done);
                    if (id == 0) void'(q0.pop_front());
                    else         void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) mon(0, bus0.inst, bus0.ext_rd_add, bus0.busy, bus0.done);
    always @(negedge clk) mon(1, bus1.inst, bus1.ext_rd_add, bus1.busy, bus1.done);

    task automatic wait_inst_bit(input int b, input int budget, input string what);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (bus0.inst[b]) begin seen = 1'b1; break; end
        end
        check({"reach_", what}, int'(seen), 1);
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_log0.size() >= n) break;
            @(negedge clk); #1;
        end
        check("done_count_dut0", done_log0.size(), n);
    endtask

    int c0;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_inst", int'(bus0.inst), 0);
        check("reset_busy", int'(bus0.busy), 0);
        check("reset_done", int'(bus0.done), 0);
        check("reset_ext", int'(bus0.ext_rd_add), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Single pass on both instances from the same edge.
        c0 = cyc;
        bus0.start = 1'b1;
        bus1.start = 1'b1;
        gen(0, 8, 8, 10, c0 + 1);
        gen(1, 1, 8, 1, c0 + 1);
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        wait_dones(1, 200);
        repeat (3) @(negedge clk);
        check("done_cycle_default", (done_log0.size() > 0) ? done_log0[0] - c0 : -1, 93);
        check("done_cycle_small", (done_log1.size() > 0) ? done_log1[0] - c0 : -1, 21);

        // Re-pulse during EXEC is ignored; reset mid-ACC aborts the pass.
        @(negedge clk);
        c0 = cyc;
        bus0.start = 1'b1;
        gen(0, 8, 8, 10, c0 + 1);
        @(negedge clk);
        bus0.start = 1'b0;
        wait_inst_bit(7, 60, "exec");
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_inst_bit(17, 100, "acc");
        #2;
        reset = 1'b1;
        q0.delete();
        #1;
        check("async_reset_inst", int'(bus0.inst), 0);
        check("async_reset_busy", int'(bus0.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_no_done", done_log0.size(), 1);

        c0 = cyc;
        bus0.start = 1'b1;
        gen(0, 8, 8, 10, c0 + 1);
        @(negedge clk);
        bus0.start = 1'b0;
        wait_dones(2, 200);
        check("done_cycle_after_reset", (done_log0.size() > 1) ? done_log0[1] - c0 : -1, 93);

        // Start held high: back-to-back passes.
        repeat (3) @(negedge clk);
        c0 = cyc;
        bus0.start = 1'b1;
        gen(0, 8, 8, 10, c0 + 1);
        gen(0, 8, 8, 10, c0 + 95);
        repeat (120) @(negedge clk);
        bus0.start = 1'b0;
        wait_dones(4, 200);
        check("b2b_first_done", (done_log0.size() > 2) ? done_log0[2] - c0 : -1, 93);
        check("b2b_second_done", (done_log0.size() > 3) ? done_log0[3] - c0 : -1, 187);

        repeat (5) @(negedge clk);
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);
        check("dut1_single_done", done_log1.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
